// File: rtl/midi_uart_rx_fifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// midi_uart_rx_fifo
//   Serial receiver for the MIDI / PicoBlaze front end. A 16x oversampled
//   receiver with 3-sample majority voting per bit, false-start rejection,
//   optional odd/even parity, sticky error flags, and a first-word-fall-through
//   receive FIFO feeding the PicoBlaze / voice-allocator input port.
//
// Ports
//   clk         in   1            system clock, all logic on posedge
//   reset       in   1            asynchronous, active-high; clears all state
//   rxd         in   1            serial input, idle high, asynchronous to clk
//   dout        out  DATA_BITS    FIFO head entry; meaningful while valid=1
//   valid       out  1            FIFO not empty
//   rd          in   1            pop FIFO head on this edge; ignored when empty
//   level       out  FIFO_AW+1    number of entries held, 0..2**FIFO_AW
//   busy        out  1            frame reception in progress
//   frame_err   out  1            sticky: stop bit sampled low
//   parity_err  out  1            sticky: parity mismatch
//   overrun     out  1            sticky: good byte arrived while FIFO full
//   clr_err     in   1            synchronous clear of the three sticky errors
// ---------------------------------------------------------------------------
module midi_uart_rx_fifo #(
    parameter int CLK_DIV   = 100,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 rd,
    output logic [FIFO_AW:0]     level,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clr_err
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]   BIT_ONE  = BIT_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when the received parity bit matches the configured parity mode.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic ones_odd;
        logic ok;
        ones_odd = (^data) ^ pbit;
        case (PARITY)
            32'sd1:  ok = ones_odd;
            32'sd2:  ok = ~ones_odd;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Registers
    logic                 sync1_q, sync2_q;
    logic [CNT_W-1:0]     tick_cnt_q;
    logic [3:0]           phase_q, phase_d;
    logic                 prev_q, prev_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_ok_q, par_ok_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, busy_q;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    // Combinational strobes
    logic rs_s, tick_s, vote_s;
    logic push_s, set_fe_s, set_pe_s;
    logic pop_s, full_s, push_ok_s, set_ovr_s;

    assign rs_s   = sync2_q;
    assign tick_s = (tick_cnt_q == CNT_LAST);
    // At the phase-9 tick the third sample is the live synchronised value.
    assign vote_s = maj3(s7_q, s8_q, rs_s);

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick_s) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_ONE;
        end
    end

    // Receiver FSM next-state, sampling and bit assembly.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        s7_d      = s7_q;
        s8_d      = s8_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        push_s    = 1'b0;
        set_fe_s  = 1'b0;
        set_pe_s  = 1'b0;
        if (tick_s) begin
            phase_d = phase_q + 4'd1;
        end else begin
            phase_d = phase_q;
        end

        if (tick_s) begin
            prev_d = rs_s;
            case (phase_q)
                4'd7:    s7_d = rs_s;
                4'd8:    s8_d = rs_s;
                default: s7_d = s7_q;
            endcase

            case (state_q)
                ST_IDLE: begin
                    // Falling edge between two ticks marks a start; phase 0 is re-anchored here.
                    if (!rs_s && prev_q) begin
                        state_d = ST_START;
                        phase_d = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (phase_q == 4'd9 && vote_s) begin
                        state_d = ST_IDLE;
                    end else if (phase_q == 4'd15) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        par_ok_d  = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (phase_q == 4'd9) begin
                        shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                    end else if (phase_q == 4'd15) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = (PARITY != 32'sd0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_ONE;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (phase_q == 4'd9) begin
                        par_ok_d = parity_ok(shift_q, vote_s);
                    end else if (phase_q == 4'd15) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    // Exiting at mid-stop leaves half a bit to catch the next start edge.
                    if (phase_q == 4'd9) begin
                        if (vote_s) begin
                            state_d = ST_IDLE;
                            if (par_ok_q) begin
                                push_s = 1'b1;
                            end else begin
                                set_pe_s = 1'b1;
                            end
                        end else begin
                            state_d  = ST_BREAK;
                            set_fe_s = 1'b1;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_BREAK: begin
                    if (rs_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receiver FSM and sampling registers. prev resets low so a line that is
    // already low when reset releases cannot look like a fresh start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= 4'd0;
            prev_q    <= 1'b0;
            s7_q      <= 1'b1;
            s8_q      <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            prev_q    <= prev_d;
            s7_q      <= s7_d;
            s8_q      <= s8_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
        end
    end

    // FIFO control: push/pop arbitration, level and next head value.
    always_comb begin
        pop_s     = rd && (level_q != '0);
        full_s    = (level_q == LVL_FULL);
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        push_ok_s = push_s && (!full_s || pop_s);
        set_ovr_s = push_s && full_s && !pop_s;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Head after this edge: the byte being written if it lands at the new head slot.
        if (level_d == '0) begin
            dout_d = '0;
        end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = shift_q;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage, pointers and registered FIFO-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            valid_q  <= (level_d != '0);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Sticky error next-state; a set in the same cycle as clr_err wins.
    always_comb begin
        if (clr_err) begin
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            frame_err_d  = frame_err_q;
            parity_err_d = parity_err_q;
            overrun_d    = overrun_q;
        end
        if (set_fe_s) begin
            frame_err_d = 1'b1;
        end else begin
            frame_err_d = frame_err_d;
        end
        if (set_pe_s) begin
            parity_err_d = 1'b1;
        end else begin
            parity_err_d = parity_err_d;
        end
        if (set_ovr_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_d;
        end
    end

    // Sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign valid      = valid_q;
    assign level      = level_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_midi_uart_rx_fifo.sv
`timescale 1ns/1ps
// Directed bench for midi_uart_rx_fifo: one no-parity instance and one
// even-parity instance, both with a short baud divisor.
module tb_midi_uart_rx_fifo;

    localparam int TB_DIV = 4;
    localparam int BT     = TB_DIV * 16;

    logic       clk;
    logic       reset;
    logic       rxd, rd, clr_err;
    logic [7:0] dout;
    logic       valid, busy, fe, pe, ovr;
    logic [2:0] level;

    logic       rxd_p, rd_p, clr_p;
    logic [7:0] dout_p;
    logic       valid_p, busy_p, fe_p, pe_p, ovr_p;
    logic [2:0] level_p;

    int n_assert = 0;
    int n_fail   = 0;

    midi_uart_rx_fifo #(.CLK_DIV(TB_DIV), .DATA_BITS(8), .PARITY(0), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .dout(dout), .valid(valid), .rd(rd),
        .level(level), .busy(busy), .frame_err(fe), .parity_err(pe), .overrun(ovr),
        .clr_err(clr_err)
    );

    midi_uart_rx_fifo #(.CLK_DIV(TB_DIV), .DATA_BITS(8), .PARITY(2), .FIFO_AW(2)) dut_p (
        .clk(clk), .reset(reset), .rxd(rxd_p), .dout(dout_p), .valid(valid_p), .rd(rd_p),
        .level(level_p), .busy(busy_p), .frame_err(fe_p), .parity_err(pe_p), .overrun(ovr_p),
        .clr_err(clr_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_line(input bit to_par, input logic v);
        if (to_par) rxd_p = v;
        else        rxd   = v;
    endtask

    // Send start, 8 data bits LSB first, optional parity, stop. The line is
    // left at the stop value. glitch_idx inverts that frame bit for one tick.
    task automatic send_frame(input bit to_par, input logic [7:0] data, input logic pbit,
                              input logic stop, input int glitch_idx);
        logic [10:0] bits;
        int          n;
        if (to_par) begin
            bits = {stop, pbit, data, 1'b0};
            n    = 11;
        end else begin
            bits = {1'b0, stop, data, 1'b0};
            n    = 10;
        end
        for (int i = 0; i < n; i++) begin
            drive_line(to_par, bits[i]);
            if (i == glitch_idx) begin
                wait_clks(BT / 2);
                drive_line(to_par, ~bits[i]);
                wait_clks(TB_DIV);
                drive_line(to_par, bits[i]);
                wait_clks(BT / 2 - TB_DIV);
            end else begin
                wait_clks(BT);
            end
        end
    endtask

    task automatic pop;
        rd = 1'b1;
        wait_clks(1);
        rd = 1'b0;
    endtask

    task automatic clear_errors;
        clr_err = 1'b1;
        wait_clks(1);
        clr_err = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rxd = 1'b1; rd = 1'b0; clr_err = 1'b0;
        rxd_p = 1'b1; rd_p = 1'b0; clr_p = 1'b0;
        wait_clks(5);
        check("rst_dout", dout, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {fe, pe, ovr}, 3'b000);
        reset = 1'b0;
        wait_clks(2 * BT);
        check("idle_level", level, 3'd0);
        check("idle_busy", busy, 1'b0);
        check("idle_p_level", level_p, 3'd0);

        // 1: plain byte
        send_frame(1'b0, 8'h90, 1'b0, 1'b1, -1);
        check("t1_valid", valid, 1'b1);
        check("t1_dout", dout, 8'h90);
        check("t1_level", level, 3'd1);
        check("t1_errs", {fe, pe, ovr}, 3'b000);
        check("t1_busy", busy, 1'b0);
        pop();
        check("t1_pop_valid", valid, 1'b0);
        check("t1_pop_level", level, 3'd0);

        // 2: false start, 4 ticks low
        rxd = 1'b0;
        wait_clks(10);
        check("t2_busy_hi", busy, 1'b1);
        wait_clks(4 * TB_DIV - 10);
        rxd = 1'b1;
        wait_clks(BT);
        check("t2_busy_lo", busy, 1'b0);
        check("t2_level", level, 3'd0);
        check("t2_errs", {fe, pe, ovr}, 3'b000);

        // 3: framing error, held break, then a good byte
        send_frame(1'b0, 8'h45, 1'b0, 1'b0, -1);
        wait_clks(3 * BT);
        rxd = 1'b1;
        wait_clks(2 * BT);
        check("t3_fe", fe, 1'b1);
        check("t3_level0", level, 3'd0);
        check("t3_valid0", valid, 1'b0);
        check("t3_busy", busy, 1'b0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1, -1);
        wait_clks(BT);
        check("t3_valid", valid, 1'b1);
        check("t3_dout", dout, 8'h3C);
        check("t3_level", level, 3'd1);
        check("t3_fe_sticky", fe, 1'b1);
        clear_errors();
        check("t3_fe_clr", fe, 1'b0);
        pop();
        check("t3_empty", level, 3'd0);

        // 4: overrun with five back-to-back bytes
        for (int i = 1; i <= 4; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b1, -1);
        check("t4_level4", level, 3'd4);
        check("t4_ovr0", ovr, 1'b0);
        send_frame(1'b0, 8'h05, 1'b0, 1'b1, -1);
        check("t4_level_full", level, 3'd4);
        check("t4_ovr1", ovr, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("t4_drain_valid", valid, 1'b1);
            check("t4_drain_dout", dout, 32'(i));
            pop();
        end
        check("t4_valid0", valid, 1'b0);
        check("t4_level0", level, 3'd0);
        check("t4_ovr_sticky", ovr, 1'b1);
        clear_errors();
        check("t4_ovr_clr", ovr, 1'b0);

        // 5: even parity instance
        send_frame(1'b1, 8'hA5, 1'b0, 1'b1, -1);
        wait_clks(BT);
        check("t5_level1", level_p, 3'd1);
        check("t5_dout", dout_p, 8'hA5);
        check("t5_pe0", pe_p, 1'b0);
        send_frame(1'b1, 8'hA5, 1'b1, 1'b1, -1);
        wait_clks(BT);
        check("t5_pe1", pe_p, 1'b1);
        check("t5_level_kept", level_p, 3'd1);
        check("t5_fe0", fe_p, 1'b0);

        // 7: one-tick glitch in the middle of data bit 2 (frame bit 3)
        send_frame(1'b0, 8'h3A, 1'b0, 1'b1, 3);
        wait_clks(BT);
        check("t7_valid", valid, 1'b1);
        check("t7_dout", dout, 8'h3A);
        check("t7_fe", fe, 1'b0);
        pop();

        // 6: reset in the middle of bit 3 of 0x7F with two bytes queued
        send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b1, -1);
        check("t6_level2", level, 3'd2);
        rxd = 1'b0;
        wait_clks(BT);
        rxd = 1'b1;
        wait_clks(3 * BT + BT / 2);
        check("t6_busy_mid", busy, 1'b1);
        reset = 1'b1;
        wait_clks(3);
        check("t6_dout", dout, 8'h00);
        check("t6_valid", valid, 1'b0);
        check("t6_level", level, 3'd0);
        check("t6_busy", busy, 1'b0);
        check("t6_errs", {fe, pe, ovr}, 3'b000);
        check("t6_p_level", level_p, 3'd0);
        check("t6_p_pe", pe_p, 1'b0);
        reset = 1'b0;
        wait_clks(2 * BT);
        check("t6_idle_level", level, 3'd0);

        // line already low when reset releases must not start a frame
        rxd = 1'b0;
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(BT);
        check("t6_low_busy", busy, 1'b0);
        rxd = 1'b1;
        wait_clks(2 * BT);
        check("t6_low_level", level, 3'd0);
        check("t6_low_errs", {fe, pe, ovr}, 3'b000);

        send_frame(1'b0, 8'hF8, 1'b0, 1'b1, -1);
        wait_clks(BT);
        check("t6_f8_valid", valid, 1'b1);
        check("t6_f8_dout", dout, 8'hF8);
        check("t6_f8_level", level, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
